// File: rtl/qtr_sampler_if.sv
// Link between qtr_sampler and the QTR reflectance front end.
// qtr_en is held high for a whole conversion; qtr_valid is a one-cycle strobe that qualifies qtr_value.
interface qtr_sampler_if;
    logic       qtr_en;
    logic [7:0] qtr_value;
    logic       qtr_valid;

    modport master (output qtr_en, input qtr_value, input qtr_valid);
    modport slave  (input qtr_en, output qtr_value, output qtr_valid);
endinterface

// File: rtl/qtr_sampler.sv
// Periodic QTR trigger with 4-sample moving average, hysteresis line flag
// and a sticky conversion timeout.
module qtr_sampler #(
    parameter int CLK_FREQUENCY  = 60_000_000,
    parameter int PERIOD_CYCLES  = 600_000,
    parameter int TIMEOUT_CYCLES = 180_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    qtr_sampler_if.master        qtr,
    input  logic [7:0]           thresh_hi,
    input  logic [7:0]           thresh_lo,
    output logic [7:0]           raw,
    output logic [7:0]           avg,
    output logic                 sample_stb,
    output logic                 on_line,
    output logic                 timeout_err,
    output logic [1:0]           dbg_state
);
    localparam int MAX_CYC = (PERIOD_CYCLES > TIMEOUT_CYCLES) ? PERIOD_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    if (CLK_FREQUENCY < 1 || PERIOD_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("qtr_sampler: frequency and cycle counts must be positive");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_UPDATE  = 2'd2,
        S_WAIT    = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] timeout_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic             first;
    logic [7:0]       samples [4];
    logic [9:0]       sum;
    logic [7:0]       avg_next;

    always_comb begin
        sum      = {2'b00, samples[0]} + {2'b00, samples[1]}
                 + {2'b00, samples[2]} + {2'b00, samples[3]};
        avg_next = sum[9:2];
    end

    // Dropping the request in the valid cycle keeps the front end from retriggering.
    assign qtr.qtr_en = (state == S_CONVERT) && !qtr.qtr_valid;
    assign dbg_state  = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            timeout_cnt <= '0;
            period_cnt  <= '0;
            first       <= 1'b0;
            raw         <= 8'h00;
            avg         <= 8'h00;
            sample_stb  <= 1'b0;
            on_line     <= 1'b0;
            timeout_err <= 1'b0;
            for (int i = 0; i < 4; i++) samples[i] <= 8'h00;
        end else begin
            sample_stb <= 1'b0;
            if (!enable) begin
                // Abort: results and buffer are kept, the next enable preloads again.
                state       <= S_IDLE;
                timeout_err <= 1'b0;
                first       <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state       <= S_CONVERT;
                        first       <= 1'b1;
                        timeout_cnt <= '0;
                    end
                    S_CONVERT: begin
                        if (qtr.qtr_valid) begin
                            raw   <= qtr.qtr_value;
                            first <= 1'b0;
                            state <= S_UPDATE;
                            if (first) begin
                                for (int i = 0; i < 4; i++) samples[i] <= qtr.qtr_value;
                            end else begin
                                samples[0] <= samples[1];
                                samples[1] <= samples[2];
                                samples[2] <= samples[3];
                                samples[3] <= qtr.qtr_value;
                            end
                        end else if (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                            timeout_err <= 1'b1;
                            state       <= S_WAIT;
                            period_cnt  <= '0;
                        end else begin
                            timeout_cnt <= timeout_cnt + 1'b1;
                        end
                    end
                    S_UPDATE: begin
                        avg        <= avg_next;
                        sample_stb <= 1'b1;
                        // Set test wins so inverted thresholds still behave deterministically.
                        if (avg_next >= thresh_hi)      on_line <= 1'b1;
                        else if (avg_next <= thresh_lo) on_line <= 1'b0;
                        state      <= S_WAIT;
                        period_cnt <= '0;
                    end
                    S_WAIT: begin
                        if (period_cnt == CNT_W'(PERIOD_CYCLES)) begin
                            state       <= S_CONVERT;
                            timeout_cnt <= '0;
                        end else begin
                            period_cnt <= period_cnt + 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_qtr_sampler.sv
// Directed bench for qtr_sampler: stimulus pushes expected {raw, avg, on_line}
// into a queue, a negedge monitor pops it on every sample_stb.
module tb_qtr_sampler;
    localparam int P = 50;
    localparam int T = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] thresh_hi, thresh_lo;
    logic [7:0] raw, avg;
    logic       sample_stb, on_line, timeout_err;
    logic [1:0] dbg_state;

    qtr_sampler_if qif ();

    qtr_sampler #(
        .CLK_FREQUENCY (60_000_000),
        .PERIOD_CYCLES (P),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .qtr        (qif.master),
        .thresh_hi  (thresh_hi),
        .thresh_lo  (thresh_lo),
        .raw        (raw),
        .avg        (avg),
        .sample_stb (sample_stb),
        .on_line    (on_line),
        .timeout_err(timeout_err),
        .dbg_state  (dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    logic [16:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_en(output int rise);
        int n = 0;
        while (!qif.qtr_en && n < 200) begin
            step();
            n++;
        end
        check("qtr_en_rise", {31'd0, qif.qtr_en}, 32'd1);
        rise = cyc;
    endtask

    task automatic rearm();
        enable = 1'b0;
        step();
        enable = 1'b1;
    endtask

    task automatic do_sample(input logic [7:0] v, input int dly, input logic [7:0] e_avg,
                             input logic e_on, output int rise);
        wait_en(rise);
        repeat (dly) step();
        qif.qtr_value = v;
        qif.qtr_valid = 1'b1;
        exp_q.push_back({v, e_avg, e_on});
        #1;
        check("qtr_en_low_in_valid", {31'd0, qif.qtr_en}, 32'd0);
        @(posedge clk);
        #1;
        qif.qtr_valid = 1'b0;
        check("raw_after_capture", {24'd0, raw}, {24'd0, v});
        check("stb_low_after_E", {31'd0, sample_stb}, 32'd0);
        step();
        check("stb_high_after_E1", {31'd0, sample_stb}, 32'd1);
        step();
        check("stb_low_after_E2", {31'd0, sample_stb}, 32'd0);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (sample_stb) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_sample_stb actual=1 required=0");
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                check("sb_raw", {24'd0, raw}, {24'd0, e[16:9]});
                check("sb_avg", {24'd0, avg}, {24'd0, e[8:1]});
                check("sb_on_line", {31'd0, on_line}, {31'd0, e[0]});
            end
        end
    end

    logic [7:0] hy_val [8] = '{8'h60, 8'h60, 8'h60, 8'h60, 8'h40, 8'h40, 8'h40, 8'h40};
    logic [7:0] hy_avg [8] = '{8'h84, 8'h78, 8'h6C, 8'h60, 8'h58, 8'h50, 8'h48, 8'h40};
    logic       hy_on  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] ma_val [5] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    logic [7:0] ma_avg [5] = '{8'h10, 8'h14, 8'h1C, 8'h28, 8'h38};
    int         ma_dly [5] = '{2, 5, 0, 7, 1};

    initial begin
        int r, r_prev;
        reset         = 1'b0;
        enable        = 1'b1;
        thresh_hi     = 8'h80;
        thresh_lo     = 8'h40;
        qif.qtr_value = 8'h00;
        qif.qtr_valid = 1'b0;
        repeat (3) step();

        // reset state
        check("rst_qtr_en", {31'd0, qif.qtr_en}, 32'd0);
        check("rst_raw", {24'd0, raw}, 32'd0);
        check("rst_avg", {24'd0, avg}, 32'd0);
        check("rst_stb", {31'd0, sample_stb}, 32'd0);
        check("rst_on_line", {31'd0, on_line}, 32'd0);
        check("rst_timeout", {31'd0, timeout_err}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        reset = 1'b1;
        check("qtr_en_before_edge", {31'd0, qif.qtr_en}, 32'd0);
        step();
        check("qtr_en_one_edge_after", {31'd0, qif.qtr_en}, 32'd1);

        // first sample preload
        do_sample(8'h40, 3, 8'h40, 1'b0, r);

        // moving average and period spacing
        thresh_hi = 8'hFF;
        thresh_lo = 8'h00;
        rearm();
        for (int i = 0; i < 5; i++) begin
            r_prev = r;
            do_sample(ma_val[i], ma_dly[i], ma_avg[i], 1'b0, r);
            if (i > 0) check("period_spacing", r - r_prev, P + ma_dly[i-1] + 1 + 2);
        end

        // hysteresis
        thresh_hi = 8'h80;
        thresh_lo = 8'h40;
        rearm();
        do_sample(8'h90, 1, 8'h90, 1'b1, r);
        for (int i = 0; i < 8; i++) do_sample(hy_val[i], 2, hy_avg[i], hy_on[i], r);
        thresh_hi = 8'h20;
        thresh_lo = 8'h30;
        rearm();
        do_sample(8'h28, 0, 8'h28, 1'b1, r);

        // timeout
        wait_en(r);
        repeat (T - 1) step();
        check("no_timeout_yet", {31'd0, timeout_err}, 32'd0);
        check("qtr_en_before_timeout", {31'd0, qif.qtr_en}, 32'd1);
        step();
        check("timeout_err_set", {31'd0, timeout_err}, 32'd1);
        check("qtr_en_after_timeout", {31'd0, qif.qtr_en}, 32'd0);
        check("timeout_state_wait", {30'd0, dbg_state}, 32'd3);
        for (int i = 0; i < 5; i++) begin
            step();
            check("timeout_no_stb", {31'd0, sample_stb}, 32'd0);
        end
        check("timeout_raw_kept", {24'd0, raw}, 32'h28);
        check("timeout_avg_kept", {24'd0, avg}, 32'h28);
        check("timeout_on_kept", {31'd0, on_line}, 32'd1);
        enable = 1'b0;
        step();
        check("timeout_cleared", {31'd0, timeout_err}, 32'd0);
        enable = 1'b1;

        // valid on the terminal cycle wins
        do_sample(8'h30, T - 1, 8'h30, 1'b1, r);
        step();
        check("valid_at_terminal_no_err", {31'd0, timeout_err}, 32'd0);

        // abort
        wait_en(r);
        repeat (3) step();
        enable        = 1'b0;
        qif.qtr_value = 8'h77;
        qif.qtr_valid = 1'b1;
        step();
        check("abort_qtr_en", {31'd0, qif.qtr_en}, 32'd0);
        check("abort_state_idle", {30'd0, dbg_state}, 32'd0);
        qif.qtr_valid = 1'b0;
        step();
        qif.qtr_valid = 1'b1;
        step();
        qif.qtr_valid = 1'b0;
        check("abort_raw_kept", {24'd0, raw}, 32'h30);
        check("abort_avg_kept", {24'd0, avg}, 32'h30);
        thresh_hi = 8'h80;
        thresh_lo = 8'h40;
        enable    = 1'b1;
        do_sample(8'h20, 2, 8'h20, 1'b0, r);

        // asynchronous reset mid-conversion
        wait_en(r);
        repeat (3) step();
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_qtr_en", {31'd0, qif.qtr_en}, 32'd0);
        check("async_rst_raw", {24'd0, raw}, 32'd0);
        check("async_rst_avg", {24'd0, avg}, 32'd0);
        check("async_rst_on_line", {31'd0, on_line}, 32'd0);
        check("async_rst_stb", {31'd0, sample_stb}, 32'd0);
        check("async_rst_timeout", {31'd0, timeout_err}, 32'd0);
        step();
        reset = 1'b1;
        step();

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
